// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter widths and lock-state encoding
// for the VGA sink path.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL         = 800;
    localparam int unsigned H_SYNC          = 96;
    localparam int unsigned H_START         = 144;
    localparam int unsigned H_ACTIVE        = 640;
    localparam int unsigned V_TOTAL         = 525;
    localparam int unsigned V_SYNC          = 2;
    localparam int unsigned V_START         = 34;
    localparam int unsigned V_ACTIVE        = 480;
    localparam bit          SYNC_ACTIVE_LOW = 1'b1;
    localparam int unsigned LOCK_FRAMES     = 2;

    localparam int unsigned HCNT_W = 11;
    localparam int unsigned VCNT_W = 10;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned RGB_W  = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Strobe-gated sync sampler: keeps the last sampled (active-high) sync level
// and flags the assertion edge combinationally in the sampling strobe cycle.
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stb_i,
    input  logic sync_i,
    output logic edge_c_o
);

    logic asserted_c;
    logic level_q;
    logic level_d;

    assign asserted_c = ACTIVE_LOW ? ~sync_i : sync_i;

    always_comb begin
        level_d = level_q;
        if (stb_i) begin
            level_d = asserted_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign edge_c_o = stb_i & asserted_c & ~level_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sink: rebuilds pixel coordinates from HS/VS, checks line/frame timing
// and qualifies active pixels once the stream has been locked.
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL         = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL         = vga_timing_pkg::V_TOTAL,
    parameter int unsigned H_START         = vga_timing_pkg::H_START,
    parameter int unsigned H_ACTIVE        = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned V_START         = vga_timing_pkg::V_START,
    parameter int unsigned V_ACTIVE        = vga_timing_pkg::V_ACTIVE,
    parameter bit          SYNC_ACTIVE_LOW = vga_timing_pkg::SYNC_ACTIVE_LOW,
    parameter int unsigned LOCK_FRAMES     = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pix_stb,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic [RGB_W-1:0] i_r,
    input  logic [RGB_W-1:0] i_g,
    input  logic [RGB_W-1:0] i_b,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    output logic [RGB_W-1:0] o_r,
    output logic [RGB_W-1:0] o_g,
    output logic [RGB_W-1:0] o_b,
    output logic             o_pix_valid,
    output logic             o_frame_start,
    output logic             o_locked,
    output logic             o_err
);

    localparam int unsigned GF_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;
    localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_LO     = HCNT_W'(H_START);
    localparam logic [HCNT_W-1:0] H_HI     = HCNT_W'(H_START + H_ACTIVE);
    localparam logic [VCNT_W-1:0] V_LO     = VCNT_W'(V_START);
    localparam logic [VCNT_W-1:0] V_HI     = VCNT_W'(V_START + V_ACTIVE);

    logic hs_edge_c;
    logic vs_edge_c;
    logic resolve_c;
    logic line_bad_c;
    logic frame_bad_c;
    logic sat_c;
    logic active_c;
    rgb_t rgb_in_c;

    logic [HCNT_W-1:0] hcnt_q,  hcnt_d;
    logic [VCNT_W-1:0] vcnt_q,  vcnt_d;
    logic              vs_pend_q, vs_pend_d;
    logic [GF_W-1:0]   gf_q,    gf_d;
    lock_state_t       state_q, state_d;

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    rgb_t           rgb_q, rgb_d;
    logic           valid_q, valid_d;
    logic           fs_q, fs_d;
    logic           locked_q, locked_d;
    logic           err_q, err_d;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_edge (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .stb_i    (i_pix_stb),
        .sync_i   (i_hs),
        .edge_c_o (hs_edge_c)
    );

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_edge (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .stb_i    (i_pix_stb),
        .sync_i   (i_vs),
        .edge_c_o (vs_edge_c)
    );

    assign rgb_in_c = '{r: i_r, g: i_g, b: i_b};

    // Counters, timing checks and lock FSM; all advance only on a pixel strobe.
    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        vs_pend_d   = vs_pend_q;
        gf_d        = gf_q;
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        rgb_d       = rgb_q;
        valid_d     = 1'b0;
        fs_d        = 1'b0;
        err_d       = 1'b0;
        resolve_c   = 1'b0;
        line_bad_c  = 1'b0;
        frame_bad_c = 1'b0;
        sat_c       = 1'b0;
        active_c    = 1'b0;

        if (i_pix_stb) begin
            resolve_c = hs_edge_c & vs_pend_q;

            if (hs_edge_c) begin
                hcnt_d     = '0;
                line_bad_c = (hcnt_q != H_LAST);
                if (resolve_c) begin
                    vcnt_d      = '0;
                    frame_bad_c = (vcnt_q != V_LAST);
                end else if (vcnt_q != VCNT_MAX) begin
                    vcnt_d = vcnt_q + VCNT_W'(1);
                    sat_c  = (vcnt_d == VCNT_MAX);
                end
            end else if (hcnt_q != HCNT_MAX) begin
                hcnt_d = hcnt_q + HCNT_W'(1);
                sat_c  = (hcnt_d == HCNT_MAX);
            end

            // A VS edge landing on the resolving HS edge re-arms for the next one.
            if (vs_edge_c) begin
                vs_pend_d = 1'b1;
            end else if (resolve_c) begin
                vs_pend_d = 1'b0;
            end

            case (state_q)
                SEARCH: begin
                    if (resolve_c) begin
                        state_d = TRACK;
                        gf_d    = '0;
                    end
                end
                TRACK: begin
                    if (line_bad_c || frame_bad_c) begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                    end else if (resolve_c) begin
                        gf_d = gf_q + GF_W'(1);
                        if (gf_d == GF_W'(LOCK_FRAMES)) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad_c || frame_bad_c || sat_c) begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase

            active_c = (hcnt_d >= H_LO) && (hcnt_d < H_HI) &&
                       (vcnt_d >= V_LO) && (vcnt_d < V_HI);
            x_d      = X_W'(hcnt_d - H_LO);
            y_d      = Y_W'(vcnt_d - V_LO);
            rgb_d    = rgb_in_c;
            valid_d  = (state_d == LOCKED) && active_c;
            fs_d     = valid_d && (hcnt_d == H_LO) && (vcnt_d == V_LO);
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            vs_pend_q <= 1'b0;
            gf_q      <= '0;
            state_q   <= SEARCH;
            x_q       <= '0;
            y_q       <= '0;
            rgb_q     <= '0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            vs_pend_q <= vs_pend_d;
            gf_q      <= gf_d;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_q     <= rgb_d;
            valid_q   <= valid_d;
            fs_q      <= fs_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_r           = rgb_q.r;
    assign o_g           = rgb_q.g;
    assign o_b           = rgb_q.b;
    assign o_pix_valid   = valid_q;
    assign o_frame_start = fs_q;
    assign o_locked      = locked_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a shrunken raster: a behavioural VGA source
// feeds the DUT and a queue scoreboard checks every qualified pixel.
module tb_vga_sync_receiver;

    localparam int H_TOTAL   = 24;
    localparam int H_SYNC    = 2;
    localparam int H_START   = 6;
    localparam int H_ACTIVE  = 12;
    localparam int V_TOTAL   = 14;
    localparam int V_SYNC    = 2;
    localparam int V_START   = 4;
    localparam int V_ACTIVE  = 6;
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

    logic       clk;
    logic       i_rst;
    logic       i_pix_stb;
    logic       i_hs;
    logic       i_vs;
    logic [3:0] i_r, i_g, i_b;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic [3:0] o_r, o_g, o_b;
    logic       o_pix_valid, o_frame_start, o_locked, o_err;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   total, bad;
    int   err_cnt, valid_cnt, fs_cnt;
    int   last_x, last_y;
    logic lock_l0, lock_l1;

    vga_sync_receiver #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
        .V_START(V_START), .V_ACTIVE(V_ACTIVE), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_x(o_x), .o_y(o_y), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_pix_valid(o_pix_valid), .o_frame_start(o_frame_start),
        .o_locked(o_locked), .o_err(o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output side of the scoreboard plus pulse counters, sampled mid-cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_err === 1'b1) err_cnt++;
            if (o_frame_start === 1'b1) fs_cnt++;
            if (o_pix_valid === 1'b1) begin
                valid_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: got x=%0d y=%0d, required no valid pulse", o_x, o_y);
                end else begin
                    e = sb.pop_front();
                    if ({o_x, o_y, o_r, o_g, o_b, o_frame_start} !== e) begin
                        bad++;
                        $display("FAIL pixel: got x=%0d y=%0d rgb=%h%h%h fs=%b, required x=%0d y=%0d rgb=%h%h%h fs=%b",
                                 o_x, o_y, o_r, o_g, o_b, o_frame_start, e.x, e.y, e.r, e.g, e.b, e.fs);
                    end
                end
            end else if (o_frame_start === 1'b1) begin
                total++;
                bad++;
                $display("FAIL frame_start_alone: got fs=1 valid=%b, required fs only with valid", o_pix_valid);
            end
        end
    endtask

    // One pixel strobe every 4 clocks; entered and left at posedge+1.
    task automatic strobe(input logic hs_a, input logic vs_a, input logic [3:0] r, input logic [3:0] g,
                          input logic [3:0] b);
        i_hs      = ~hs_a;
        i_vs      = ~vs_a;
        i_r       = r;
        i_g       = g;
        i_b       = b;
        i_pix_stb = 1'b1;
        @(posedge clk);
        #1;
        i_pix_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Source line L (0 = VS line) maps to receiver row L-1, line 0 to the previous frame's last row.
    task automatic gen_pixel(input int line, input int px, input bit exp_on);
        int   ry;
        int   x;
        int   y;
        exp_t e;
        ry = (line == 0) ? V_TOTAL - 1 : line - 1;
        x  = px - H_START;
        y  = ry - V_START;
        if (exp_on && px >= H_START && px < H_START + H_ACTIVE && ry >= V_START && ry < V_START + V_ACTIVE) begin
            e.x  = 10'(x);
            e.y  = 9'(y);
            e.r  = 4'(x);
            e.g  = 4'(y);
            e.b  = 4'hF;
            e.fs = (x == 0) && (y == 0);
            sb.push_back(e);
        end
        last_x = x;
        last_y = y;
        strobe(px < H_SYNC, line < V_SYNC, 4'(x), 4'(y), 4'hF);
    endtask

    task automatic gen_line(input int line, input int first_px, input int len, input bit exp_on);
        for (int p = first_px; p < len; p++) gen_pixel(line, p, exp_on);
    endtask

    task automatic send_frame(input int n_lines, input int short_line, input int cutoff);
        for (int l = 0; l < n_lines; l++) begin
            gen_line(l, 0, (l == short_line) ? H_TOTAL - 1 : H_TOTAL, l < cutoff);
            if (l == 0) lock_l0 = o_locked;
            if (l == 1) lock_l1 = o_locked;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        total++;
        if ({o_x, o_y, o_r, o_g, o_b, o_pix_valid, o_frame_start, o_locked, o_err} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d rgb=%h%h%h v=%b fs=%b lk=%b err=%b, required all 0",
                     o_x, o_y, o_r, o_g, o_b, o_pix_valid, o_frame_start, o_locked, o_err);
        end
    endtask

    task automatic test_lock();
        send_frame(V_TOTAL, -1, 0);
        send_frame(V_TOTAL, -1, 0);
        total++;
        if (lock_l1 !== 1'b0 || o_locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_early: got %b/%b, required 0/0 after second resolution", lock_l1, o_locked);
        end
        valid_cnt = 0;
        fs_cnt    = 0;
        send_frame(V_TOTAL, -1, V_TOTAL);
        total++;
        if (lock_l0 !== 1'b0 || lock_l1 !== 1'b1) begin
            bad++;
            $display("FAIL lock_rise: got before=%b after=%b, required 0 then 1 at third resolution", lock_l0, lock_l1);
        end
        total++;
        if (valid_cnt !== FRAME_PIX) begin
            bad++;
            $display("FAIL valid_count: got %0d, required %0d", valid_cnt, FRAME_PIX);
        end
        total++;
        if (fs_cnt !== 1 || err_cnt !== 0) begin
            bad++;
            $display("FAIL fs_err_count: got fs=%0d err=%0d, required fs=1 err=0", fs_cnt, err_cnt);
        end
    endtask

    task automatic test_short_line();
        int e0;
        e0 = err_cnt;
        send_frame(V_TOTAL, 7, 8);
        total++;
        if (err_cnt - e0 !== 1 || o_locked !== 1'b0) begin
            bad++;
            $display("FAIL short_line: got err=%0d locked=%b, required err=1 locked=0", err_cnt - e0, o_locked);
        end
        send_frame(V_TOTAL, -1, 0);
        send_frame(V_TOTAL, -1, 0);
        total++;
        if (lock_l1 !== 1'b0) begin
            bad++;
            $display("FAIL short_line_relock_early: got %b, required 0", lock_l1);
        end
        send_frame(V_TOTAL, -1, V_TOTAL);
        total++;
        if (lock_l1 !== 1'b1 || err_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL short_line_relock: got locked=%b err=%0d, required locked=1 err=1", lock_l1, err_cnt - e0);
        end
    endtask

    task automatic test_short_frame();
        int e0;
        e0 = err_cnt;
        send_frame(V_TOTAL - 1, -1, V_TOTAL - 1);
        total++;
        if (err_cnt - e0 !== 0 || o_locked !== 1'b1) begin
            bad++;
            $display("FAIL short_frame_pre: got err=%0d locked=%b, required err=0 locked=1", err_cnt - e0, o_locked);
        end
        send_frame(V_TOTAL, -1, 1);
        total++;
        if (err_cnt - e0 !== 1 || lock_l1 !== 1'b0) begin
            bad++;
            $display("FAIL short_frame_err: got err=%0d locked=%b, required err=1 locked=0", err_cnt - e0, lock_l1);
        end
        send_frame(V_TOTAL, -1, 0);
        total++;
        if (err_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL search_first_resolution: got err=%0d, required 1", err_cnt - e0);
        end
        send_frame(V_TOTAL, -1, 0);
        send_frame(V_TOTAL, -1, V_TOTAL);
        total++;
        if (lock_l1 !== 1'b1) begin
            bad++;
            $display("FAIL short_frame_relock: got %b, required 1", lock_l1);
        end
    endtask

    task automatic test_hs_stuck();
        int e0;
        e0 = err_cnt;
        repeat (2000) strobe(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        total++;
        if (err_cnt - e0 !== 0 || o_locked !== 1'b1) begin
            bad++;
            $display("FAIL hs_stuck_presat: got err=%0d locked=%b, required err=0 locked=1", err_cnt - e0, o_locked);
        end
        repeat (100) strobe(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        total++;
        if (err_cnt - e0 !== 1 || o_locked !== 1'b0) begin
            bad++;
            $display("FAIL hs_stuck_sat: got err=%0d locked=%b, required err=1 locked=0", err_cnt - e0, o_locked);
        end
        repeat (200) strobe(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        total++;
        if (err_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL hs_stuck_search: got err=%0d, required 1", err_cnt - e0);
        end
        send_frame(V_TOTAL, -1, 0);
        send_frame(V_TOTAL, -1, 0);
        send_frame(V_TOTAL, -1, V_TOTAL);
        total++;
        if (lock_l1 !== 1'b1 || err_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL hs_stuck_relock: got locked=%b err=%0d, required locked=1 err=1", lock_l1, err_cnt - e0);
        end
    endtask

    task automatic test_reset_midline();
        int e0;
        e0 = err_cnt;
        for (int l = 0; l < 7; l++) gen_line(l, 0, H_TOTAL, 1'b1);
        gen_line(7, 0, 8, 1'b1);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        total++;
        if ({o_x, o_y, o_r, o_g, o_b, o_pix_valid, o_frame_start, o_locked, o_err} !== 36'd0 || sb.size() != 0) begin
            bad++;
            $display("FAIL reset_midline: got x=%0d y=%0d rgb=%h%h%h lk=%b pending=%0d, required all 0",
                     o_x, o_y, o_r, o_g, o_b, o_locked, sb.size());
        end
        gen_line(7, 8, H_TOTAL, 1'b0);
        for (int l = 8; l < V_TOTAL; l++) gen_line(l, 0, H_TOTAL, 1'b0);
        send_frame(V_TOTAL, -1, 0);
        total++;
        if (lock_l1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_relock_f1: got %b, required 0", lock_l1);
        end
        send_frame(V_TOTAL, -1, 0);
        total++;
        if (lock_l1 !== 1'b0 || o_locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_relock_f2: got %b/%b, required 0/0", lock_l1, o_locked);
        end
        send_frame(V_TOTAL, -1, V_TOTAL);
        total++;
        if (lock_l1 !== 1'b1 || err_cnt - e0 !== 0) begin
            bad++;
            $display("FAIL reset_relock: got locked=%b err=%0d, required locked=1 err=0", lock_l1, err_cnt - e0);
        end
    endtask

    task automatic test_no_strobe();
        int e0, v0, f0;
        e0 = err_cnt;
        v0 = valid_cnt;
        f0 = fs_cnt;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            i_hs = 1'($urandom);
            i_vs = 1'($urandom);
            i_r  = 4'($urandom);
            i_g  = 4'($urandom);
            i_b  = 4'($urandom);
        end
        i_hs = 1'b1;
        i_vs = 1'b1;
        total++;
        if (o_x !== 10'(last_x) || o_y !== 9'(last_y) || o_r !== 4'(last_x) || o_g !== 4'(last_y) ||
            o_b !== 4'hF || o_locked !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: got x=%0d y=%0d rgb=%h%h%h lk=%b, required x=%0d y=%0d rgb=%h%hf lk=1",
                     o_x, o_y, o_r, o_g, o_b, o_locked, 10'(last_x), 9'(last_y), 4'(last_x), 4'(last_y));
        end
        total++;
        if (err_cnt != e0 || valid_cnt != v0 || fs_cnt != f0) begin
            bad++;
            $display("FAIL stall_pulses: got err=%0d valid=%0d fs=%0d, required 0 0 0",
                     err_cnt - e0, valid_cnt - v0, fs_cnt - f0);
        end
        send_frame(V_TOTAL, -1, V_TOTAL);
        total++;
        if (err_cnt != e0 || o_locked !== 1'b1 || valid_cnt - v0 != FRAME_PIX) begin
            bad++;
            $display("FAIL stall_resume: got err=%0d locked=%b valid=%0d, required err=0 locked=1 valid=%0d",
                     err_cnt - e0, o_locked, valid_cnt - v0, FRAME_PIX);
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_pix_stb = 1'b0;
        i_hs      = 1'b1;
        i_vs      = 1'b1;
        i_r       = 4'h0;
        i_g       = 4'h0;
        i_b       = 4'h0;
        total     = 0;
        bad       = 0;
        err_cnt   = 0;
        valid_cnt = 0;
        fs_cnt    = 0;
        last_x    = 0;
        last_y    = 0;
        lock_l0   = 1'b0;
        lock_l1   = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_lock();
        test_short_line();
        test_short_frame();
        test_hs_stuck();
        test_reset_midline();
        test_no_strobe();
        repeat (4) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pixels outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
